// File: rtl/ex_forwarding_unit_pkg.sv
// Shared constants for the EX-stage forwarding logic: operand select codes
// and the default register-index width.
package ex_forwarding_unit_pkg;

  localparam int N_BITS_REG_DEF = 5;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_NONE   = 2'b00;
  localparam fwd_sel_t FWD_EX_MEM = 2'b10;
  localparam fwd_sel_t FWD_MEM_WB = 2'b01;

endpackage

// File: rtl/ex_forwarding_unit_fwd_select.sv
// Forwarding select for one ALU operand: picks EX/MEM, MEM/WB or the register
// file value for a single source register index.
module fwd_select
  import ex_forwarding_unit_pkg::*;
#(
  parameter int N_BITS_REG = N_BITS_REG_DEF
) (
  input  logic [N_BITS_REG-1:0] i_src,
  input  logic [N_BITS_REG-1:0] i_rd_ex_mem,
  input  logic                  i_reg_write_ex_mem,
  input  logic [N_BITS_REG-1:0] i_rd_mem_wb,
  input  logic                  i_reg_write_mem_wb,
  output logic [1:0]            o_sel
);

  logic ex_hit;
  logic mem_hit;

  // Register 0 is hard-wired to zero, so a write to it must never be forwarded.
  assign ex_hit  = i_reg_write_ex_mem && (i_rd_ex_mem != '0) && (i_rd_ex_mem == i_src);
  assign mem_hit = i_reg_write_mem_wb && (i_rd_mem_wb != '0) && (i_rd_mem_wb == i_src);

  // EX/MEM holds the younger result, so it takes priority over MEM/WB.
  always_comb begin
    o_sel = FWD_NONE;
    if (ex_hit) begin
      o_sel = FWD_EX_MEM;
    end else if (mem_hit) begin
      o_sel = FWD_MEM_WB;
    end
  end

endmodule

// File: rtl/ex_forwarding_unit.sv
// EX-stage data-hazard forwarding unit: combinational operand A/B selects plus
// a registered copy of both for pipeline tracing.
module ex_forwarding_unit
  import ex_forwarding_unit_pkg::*;
#(
  parameter int N_BITS_REG = N_BITS_REG_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [N_BITS_REG-1:0] i_rs_ID,
  input  logic [N_BITS_REG-1:0] i_rt_ID,
  input  logic [N_BITS_REG-1:0] i_rd_EX_MEM,
  input  logic                  i_regWrite_EX_MEM,
  input  logic [N_BITS_REG-1:0] i_rd_MEM_WB,
  input  logic                  i_regWrite_MEM_WB,
  output logic [1:0]            o_forward_A,
  output logic [1:0]            o_forward_B,
  output logic [1:0]            o_forward_A_q,
  output logic [1:0]            o_forward_B_q
);

  logic [1:0] fwd_a_d;
  logic [1:0] fwd_b_d;
  logic [1:0] fwd_a_q;
  logic [1:0] fwd_b_q;

  fwd_select #(.N_BITS_REG(N_BITS_REG)) u_sel_a (
    .i_src              (i_rs_ID),
    .i_rd_ex_mem        (i_rd_EX_MEM),
    .i_reg_write_ex_mem (i_regWrite_EX_MEM),
    .i_rd_mem_wb        (i_rd_MEM_WB),
    .i_reg_write_mem_wb (i_regWrite_MEM_WB),
    .o_sel              (o_forward_A)
  );

  fwd_select #(.N_BITS_REG(N_BITS_REG)) u_sel_b (
    .i_src              (i_rt_ID),
    .i_rd_ex_mem        (i_rd_EX_MEM),
    .i_reg_write_ex_mem (i_regWrite_EX_MEM),
    .i_rd_mem_wb        (i_rd_MEM_WB),
    .i_reg_write_mem_wb (i_regWrite_MEM_WB),
    .o_sel              (o_forward_B)
  );

  always_comb begin
    fwd_a_d = o_forward_A;
    fwd_b_d = o_forward_B;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fwd_a_q <= FWD_NONE;
      fwd_b_q <= FWD_NONE;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign o_forward_A_q = fwd_a_q;
  assign o_forward_B_q = fwd_b_q;

endmodule

// File: tb/tb_ex_forwarding_unit.sv
// Self-checking bench for ex_forwarding_unit: directed hazard cases, reset
// behaviour of the traced selects, and a random back-to-back stream.
module tb_ex_forwarding_unit;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rde;
    logic       rwe;
    logic [4:0] rdm;
    logic       rwm;
    logic [1:0] ea;
    logic [1:0] eb;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs_id, rt_id, rd_ex_mem, rd_mem_wb;
  logic       rw_ex_mem, rw_mem_wb;
  logic [1:0] fwd_a, fwd_b, fwd_a_q, fwd_b_q;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [3:0] exp_q[$];

  ex_forwarding_unit #(.N_BITS_REG(5)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_rs_ID           (rs_id),
    .i_rt_ID           (rt_id),
    .i_rd_EX_MEM       (rd_ex_mem),
    .i_regWrite_EX_MEM (rw_ex_mem),
    .i_rd_MEM_WB       (rd_mem_wb),
    .i_regWrite_MEM_WB (rw_mem_wb),
    .o_forward_A       (fwd_a),
    .o_forward_B       (fwd_b),
    .o_forward_A_q     (fwd_a_q),
    .o_forward_B_q     (fwd_b_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(int rs, int rt, int rde, int rwe, int rdm, int rwm,
                              logic [1:0] ea, logic [1:0] eb);
    vec_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.rde = 5'(rde); v.rwe = 1'(rwe);
    v.rdm = 5'(rdm); v.rwm = 1'(rwm); v.ea = ea; v.eb = eb;
    return v;
  endfunction

  // Reference: younger EX/MEM wins, register 0 and non-writing stages never forward.
  function automatic logic [1:0] model_sel(logic [4:0] src, logic [4:0] rde, logic rwe,
                                           logic [4:0] rdm, logic rwm);
    if (src == 5'd0) return 2'b00;
    if (rwe && rde == src) return 2'b10;
    if (rwm && rdm == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic apply(vec_t v);
    rs_id = v.rs; rt_id = v.rt;
    rd_ex_mem = v.rde; rw_ex_mem = v.rwe;
    rd_mem_wb = v.rdm; rw_mem_wb = v.rwm;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    rst_n = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(4'b0000);
    exp = exp_q.pop_front();
    total_cnt++;
    if ({fwd_a_q, fwd_b_q} !== exp)
      $display("FAIL reset_q: got A_q=%b B_q=%b expected %b", fwd_a_q, fwd_b_q, exp);
    else pass_cnt++;
    // Combinational path ignores reset.
    @(negedge clk);
    apply(mk(1, 2, 1, 1, 0, 0, 2'b10, 2'b00));
    exp_q.push_back(4'b1000);
    #1;
    exp = exp_q.pop_front();
    total_cnt++;
    if ({fwd_a, fwd_b} !== exp)
      $display("FAIL reset_comb: got A=%b B=%b expected %b", fwd_a, fwd_b, exp);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed(string name, vec_t v[$]);
    logic [3:0] exp;
    foreach (v[i]) begin
      @(negedge clk);
      apply(v[i]);
      exp_q.push_back({v[i].ea, v[i].eb});
      #1;
      exp = exp_q.pop_front();
      total_cnt++;
      if ({fwd_a, fwd_b} !== exp)
        $display("FAIL %s[%0d]: got A=%b B=%b expected A=%b B=%b",
                 name, i, fwd_a, fwd_b, exp[3:2], exp[1:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_no_hazard();
    vec_t v[$];
    v.push_back(mk(1, 2, 0, 0, 0, 0, 2'b00, 2'b00));
    v.push_back(mk(1, 2, 3, 1, 4, 1, 2'b00, 2'b00));
    test_directed("no_hazard", v);
  endtask

  task automatic test_ex_hazard();
    vec_t v[$];
    v.push_back(mk(1, 2, 1, 1, 0, 0, 2'b10, 2'b00));
    v.push_back(mk(1, 2, 2, 1, 0, 0, 2'b00, 2'b10));
    v.push_back(mk(31, 31, 31, 1, 0, 0, 2'b10, 2'b10));
    test_directed("ex_hazard", v);
  endtask

  task automatic test_mem_hazard();
    vec_t v[$];
    v.push_back(mk(3, 4, 0, 0, 3, 1, 2'b01, 2'b00));
    v.push_back(mk(3, 4, 0, 0, 4, 1, 2'b00, 2'b01));
    v.push_back(mk(9, 9, 0, 0, 9, 1, 2'b01, 2'b01));
    test_directed("mem_hazard", v);
  endtask

  task automatic test_priority();
    vec_t v[$];
    v.push_back(mk(5, 6, 5, 1, 5, 1, 2'b10, 2'b00));
    v.push_back(mk(5, 6, 6, 1, 5, 1, 2'b01, 2'b10));
    v.push_back(mk(5, 6, 5, 0, 5, 1, 2'b01, 2'b00));
    test_directed("priority", v);
  endtask

  task automatic test_zero_gating();
    vec_t v[$];
    v.push_back(mk(0, 0, 0, 1, 0, 1, 2'b00, 2'b00));
    v.push_back(mk(7, 2, 7, 0, 0, 0, 2'b00, 2'b00));
    v.push_back(mk(7, 8, 0, 1, 8, 0, 2'b00, 2'b00));
    v.push_back(mk(7, 8, 23, 1, 7, 1, 2'b01, 2'b00));
    test_directed("zero_gating", v);
  endtask

  task automatic test_registered();
    logic [3:0] exp;
    @(negedge clk);
    rst_n = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({fwd_a_q, fwd_b_q} !== 4'b0000)
      $display("FAIL reg_hold_reset: got A_q=%b B_q=%b expected 00 00", fwd_a_q, fwd_b_q);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(1, 2, 1, 1, 0, 0, 2'b10, 2'b00));
    exp_q.push_back(4'b1000);
    #1;
    total_cnt++;
    if (fwd_a !== 2'b10 || fwd_a_q !== 2'b00)
      $display("FAIL reg_zero_latency: got A=%b A_q=%b expected A=10 A_q=00", fwd_a, fwd_a_q);
    else pass_cnt++;
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    total_cnt++;
    if ({fwd_a_q, fwd_b_q} !== exp)
      $display("FAIL reg_track: got A_q=%b B_q=%b expected %b", fwd_a_q, fwd_b_q, exp);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total_cnt++;
    if (fwd_a_q !== 2'b00 || fwd_a !== 2'b10)
      $display("FAIL reg_mid_reset: got A_q=%b A=%b expected A_q=00 A=10", fwd_a_q, fwd_a);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (fwd_a_q !== 2'b10)
      $display("FAIL reg_after_release: got A_q=%b expected 10", fwd_a_q);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    vec_t v;
    logic [3:0] exp;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      v = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1), 2'b00, 2'b00);
      v.ea = model_sel(v.rs, v.rde, v.rwe, v.rdm, v.rwm);
      v.eb = model_sel(v.rt, v.rde, v.rwe, v.rdm, v.rwm);
      apply(v);
      exp_q.push_back({v.ea, v.eb});
      #1;
      total_cnt++;
      if ({fwd_a, fwd_b} !== {v.ea, v.eb})
        $display("FAIL b2b_comb[%0d]: got A=%b B=%b expected A=%b B=%b",
                 n, fwd_a, fwd_b, v.ea, v.eb);
      else pass_cnt++;
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      total_cnt++;
      if ({fwd_a_q, fwd_b_q} !== exp)
        $display("FAIL b2b_q[%0d]: got A_q=%b B_q=%b expected A_q=%b B_q=%b",
                 n, fwd_a_q, fwd_b_q, exp[3:2], exp[1:0]);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rs_id = '0; rt_id = '0; rd_ex_mem = '0; rd_mem_wb = '0;
    rw_ex_mem = 1'b0; rw_mem_wb = 1'b0;
    test_reset();
    test_no_hazard();
    test_ex_hazard();
    test_mem_hazard();
    test_priority();
    test_zero_gating();
    test_registered();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
